// File: rtl/prefix_expr_tx.sv
// prefix_expr_tx
//   Transmit side of the expression token interface. It loads one packed
//   19-token expression, optionally checks its structure, and then replays it
//   one token per cycle as a valid/opt/data stream.
//
// Configuration macro: PREFIX_EXPR_TX_CHECK_EN
//   defined   : CHECK and ERR states exist. A malformed expression raises a
//               one-cycle err pulse and no tokens are sent.
//   undefined : no checking. IDLE goes straight to SEND, err is tied 0 and
//               malformed expressions are sent verbatim.
//
// Ports
//   clk       in   1            rising-edge clock
//   rst_n     in   1            asynchronous, active-low reset
//   start     in   1            load request, sampled only in IDLE
//   opt_in    in   1            0: prefix expression, 1: infix expression
//   expr_in   in   N_TOK*TOK_W  packed tokens, token 0 in the top slice
//   busy      out  1            high while the FSM is outside IDLE
//   tx_valid  out  1            token valid, N_TOK consecutive cycles
//   tx_opt    out  1            opt copy on the first token only
//   tx_data   out  TOK_W        current token, 0 when not valid
//   done      out  1            one-cycle pulse after the last token
//   err       out  1            one-cycle pulse on a malformed expression
module prefix_expr_tx #(
  parameter int TOK_W = 5,
  parameter int N_TOK = 19
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   opt_in,
  input  logic [N_TOK*TOK_W-1:0] expr_in,
  output logic                   busy,
  output logic                   tx_valid,
  output logic                   tx_opt,
  output logic [TOK_W-1:0]       tx_data,
  output logic                   done,
  output logic                   err
);

  localparam int CNT_W = $clog2(N_TOK);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TOK - 1);

`ifdef PREFIX_EXPR_TX_CHECK_EN
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SEND, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;
`endif

  state_t                   state, state_d;
  logic [CNT_W-1:0]         cnt, cnt_d;
  logic [N_TOK*TOK_W-1:0]   expr_q;
  logic                     opt_q;
  logic                     load;
  logic [TOK_W-1:0]         tokens [N_TOK];
  logic [TOK_W-1:0]         cur_tok;

  // Unpack the held expression so the current token is a simple array read.
  always_comb begin
    for (int k = 0; k < N_TOK; k++) begin
      tokens[k] = expr_q[TOK_W*(N_TOK-1-k) +: TOK_W];
    end
  end

  assign cur_tok = tokens[cnt];

`ifdef PREFIX_EXPR_TX_CHECK_EN
  logic [4:0] need, need_d, need_after;
  logic       bad, bad_d, tok_bad, is_op;
`endif

  // Next-state logic. CHECK always walks every token so its duration is
  // fixed; the sticky bad flag decides between SEND and ERR on the last one.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    load    = 1'b0;
`ifdef PREFIX_EXPR_TX_CHECK_EN
    need_d     = need;
    bad_d      = bad;
    need_after = need;
    tok_bad    = 1'b0;
    is_op      = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          load  = 1'b1;
          cnt_d = '0;
`ifdef PREFIX_EXPR_TX_CHECK_EN
          need_d  = 5'd1;
          bad_d   = 1'b0;
          state_d = S_CHECK;
`else
          state_d = S_SEND;
`endif
        end
      end
`ifdef PREFIX_EXPR_TX_CHECK_EN
      S_CHECK: begin
        is_op   = cur_tok[TOK_W-1];
        // Operator codes above the four arithmetic ones are illegal.
        tok_bad = is_op && (cur_tok[TOK_W-2:2] != '0);
        if (opt_q) begin
          // Infix: operands on even indices, operators on odd ones.
          if (is_op != cnt[0]) tok_bad = 1'b1;
        end else begin
          // Prefix: need counts operands still owed; it must stay positive
          // until the final token and land exactly on zero.
          if (need == 5'd0) tok_bad = 1'b1;
          need_after = is_op ? need + 5'd1 : need - 5'd1;
          if (cnt == LAST && need_after != 5'd0) tok_bad = 1'b1;
        end
        bad_d  = bad | tok_bad;
        need_d = need_after;
        if (cnt == LAST) begin
          cnt_d   = '0;
          state_d = bad_d ? S_ERR : S_SEND;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_ERR: state_d = S_IDLE;
`endif
      S_SEND: begin
        if (cnt == LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, captured expression and registered outputs. Outputs follow the
  // state one cycle later, which is what places tx_valid, done and err on
  // their expected cycles relative to the start sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      expr_q   <= '0;
      opt_q    <= 1'b0;
      busy     <= 1'b0;
      tx_valid <= 1'b0;
      tx_opt   <= 1'b0;
      tx_data  <= '0;
      done     <= 1'b0;
`ifdef PREFIX_EXPR_TX_CHECK_EN
      need     <= 5'd0;
      bad      <= 1'b0;
      err      <= 1'b0;
`endif
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (load) begin
        expr_q <= expr_in;
        opt_q  <= opt_in;
      end
      busy     <= (state != S_IDLE);
      tx_valid <= (state == S_SEND);
      tx_data  <= (state == S_SEND) ? cur_tok : '0;
      tx_opt   <= (state == S_SEND && cnt == '0) ? opt_q : 1'b0;
      done     <= (state == S_DONE);
`ifdef PREFIX_EXPR_TX_CHECK_EN
      need     <= need_d;
      bad      <= bad_d;
      err      <= (state == S_ERR);
`endif
    end
  end

`ifndef PREFIX_EXPR_TX_CHECK_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_prefix_expr_tx.sv
// tb_prefix_expr_tx
//   Self-checking bench for prefix_expr_tx. A cycle-indexed expectation
//   table is filled whenever the reference model accepts a load; every cycle
//   all outputs are compared against it. Well-formedness is judged by a
//   right-to-left stack evaluation (prefix) or an alternation rule (infix).
//   Honours PREFIX_EXPR_TX_CHECK_EN the same way the design does.
module tb_prefix_expr_tx;

  localparam int TOK_W = 5;
  localparam int N_TOK = 19;
  localparam int MAXC  = 4096;
`ifdef PREFIX_EXPR_TX_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
  localparam int LAT      = N_TOK;
`else
  localparam bit CHECK_EN = 1'b0;
  localparam int LAT      = 0;
`endif

  typedef logic [N_TOK*TOK_W-1:0] expr_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             opt_in;
  expr_t            expr_in;
  logic             busy;
  logic             tx_valid;
  logic             tx_opt;
  logic [TOK_W-1:0] tx_data;
  logic             done;
  logic             err;

  prefix_expr_tx #(.TOK_W(TOK_W), .N_TOK(N_TOK)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .opt_in   (opt_in),
    .expr_in  (expr_in),
    .busy     (busy),
    .tx_valid (tx_valid),
    .tx_opt   (tx_opt),
    .tx_data  (tx_data),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit             exp_busy  [MAXC];
  bit             exp_valid [MAXC];
  bit             exp_opt   [MAXC];
  bit             exp_done  [MAXC];
  bit             exp_err   [MAXC];
  bit [TOK_W-1:0] exp_data  [MAXC];

  int cyc;
  int next_free;
  int checks;
  int passes;

  function automatic logic [TOK_W-1:0] getTok(input expr_t e, input int k);
    return e[TOK_W*(N_TOK-1-k) +: TOK_W];
  endfunction

  // Prefix validity by evaluating right to left with an operand stack.
  function automatic bit isMalformed(input expr_t e, input logic op);
    int depth;
    bit bad;
    logic [TOK_W-1:0] t;
    bad = 1'b0;
    depth = 0;
    for (int k = 0; k < N_TOK; k++) begin
      if (getTok(e, k) >= 5'b10100) bad = 1'b1;
    end
    if (op) begin
      for (int k = 0; k < N_TOK; k++) begin
        t = getTok(e, k);
        if (t[TOK_W-1] != ((k % 2) == 1)) bad = 1'b1;
      end
    end else begin
      for (int k = N_TOK - 1; k >= 0; k--) begin
        t = getTok(e, k);
        if (!t[TOK_W-1]) depth++;
        else if (depth < 2) bad = 1'b1;
        else depth--;
      end
      if (depth != 1) bad = 1'b1;
    end
    return bad;
  endfunction

  function automatic expr_t genPrefix();
    expr_t e;
    int ops_left, nds_left, need;
    bit can_op, can_nd, pick_op;
    e = '0;
    ops_left = 9;
    nds_left = 10;
    need = 1;
    for (int k = 0; k < N_TOK; k++) begin
      can_op  = (ops_left > 0);
      can_nd  = (nds_left > 0) && (need > 1 || ops_left == 0);
      pick_op = can_op && (!can_nd || ($urandom_range(1, 0) == 1));
      if (pick_op) begin
        e[TOK_W*(N_TOK-1-k) +: TOK_W] = {3'b100, 2'($urandom_range(3, 0))};
        ops_left--;
        need++;
      end else begin
        e[TOK_W*(N_TOK-1-k) +: TOK_W] = {1'b0, 4'($urandom_range(15, 0))};
        nds_left--;
        need--;
      end
    end
    return e;
  endfunction

  function automatic expr_t genInfix();
    expr_t e;
    e = '0;
    for (int k = 0; k < N_TOK; k++) begin
      if (k % 2 == 0) e[TOK_W*(N_TOK-1-k) +: TOK_W] = {1'b0, 4'($urandom_range(15, 0))};
      else            e[TOK_W*(N_TOK-1-k) +: TOK_W] = {3'b100, 2'($urandom_range(3, 0))};
    end
    return e;
  endfunction

  function automatic expr_t corrupt(input expr_t e);
    expr_t r;
    int k;
    r = e;
    k = int'($urandom_range(N_TOK - 1, 0));
    r[TOK_W*(N_TOK-1-k) +: TOK_W] = 5'($urandom_range(31, 0));
    return r;
  endfunction

  // Record everything an accepted load should produce, by absolute cycle.
  task automatic modelLoad(input int e, input expr_t ex, input logic op);
    bit bad;
    bad = CHECK_EN && isMalformed(ex, op);
    if (e + LAT + N_TOK + 3 >= MAXC) begin
      $display("[TB] FAIL table_overflow at cycle %0d", e);
      $fatal(1, "[TB] expectation table exhausted");
    end
    if (bad) begin
      for (int c = e + 1; c <= e + N_TOK + 1; c++) exp_busy[c] = 1'b1;
      exp_err[e + N_TOK + 1] = 1'b1;
      next_free = e + N_TOK + 2;
    end else begin
      for (int c = e + 1; c <= e + LAT + N_TOK + 1; c++) exp_busy[c] = 1'b1;
      for (int k = 0; k < N_TOK; k++) begin
        exp_valid[e + LAT + 1 + k] = 1'b1;
        exp_data [e + LAT + 1 + k] = getTok(ex, k);
      end
      exp_opt [e + LAT + 1] = op;
      exp_done[e + LAT + N_TOK + 1] = 1'b1;
      next_free = e + LAT + N_TOK + 2;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expected);
    checks++;
    assert (obs === expected) begin
      passes++;
    end else begin
      $error("[TB] FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("busy",     32'(busy),     32'(exp_busy[cyc]));
    checkOutput("tx_valid", 32'(tx_valid), 32'(exp_valid[cyc]));
    checkOutput("tx_data",  32'(tx_data),  32'(exp_data[cyc]));
    checkOutput("tx_opt",   32'(tx_opt),   32'(exp_opt[cyc]));
    checkOutput("done",     32'(done),     32'(exp_done[cyc]));
    checkOutput("err",      32'(err),      32'(exp_err[cyc]));
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_busy"},  32'(busy),     32'd0);
    checkOutput({tag, "_valid"}, 32'(tx_valid), 32'd0);
    checkOutput({tag, "_data"},  32'(tx_data),  32'd0);
    checkOutput({tag, "_opt"},   32'(tx_opt),   32'd0);
    checkOutput({tag, "_done"},  32'(done),     32'd0);
    checkOutput({tag, "_err"},   32'(err),      32'd0);
  endtask

  // One clock: the model sees the inputs sampled at the edge, outputs are
  // compared half a cycle later.
  task automatic stepCycle();
    @(posedge clk);
    cyc++;
    if (rst_n && start && cyc >= next_free) modelLoad(cyc, expr_in, opt_in);
    @(negedge clk);
    checkAll();
  endtask

  task automatic applyStimulus(input expr_t e, input logic op);
    start   = 1'b1;
    expr_in = e;
    opt_in  = op;
    stepCycle();
    start = 1'b0;
    for (int i = 0; i < LAT + N_TOK + 3; i++) begin
      expr_in = {$urandom, $urandom, $urandom};
      opt_in  = 1'($urandom_range(1, 0));
      start   = (i == 4);
      stepCycle();
    end
    start = 1'b0;
  endtask

  expr_t e_dir;
  int    load_cyc;

  initial begin
    for (int c = 0; c < MAXC; c++) begin
      exp_busy[c] = 1'b0; exp_valid[c] = 1'b0; exp_opt[c] = 1'b0;
      exp_done[c] = 1'b0; exp_err[c] = 1'b0; exp_data[c] = '0;
    end
    cyc = 0; next_free = 0; checks = 0; passes = 0;
    rst_n = 1'b0; start = 1'b0; opt_in = 1'b0; expr_in = '0;

    @(negedge clk);
    checkZero("reset");
    rst_n = 1'b1;
    stepCycle();
    stepCycle();

    // Nine '+' then ten operands of value 1.
    e_dir = '0;
    for (int k = 0; k < N_TOK; k++)
      e_dir[TOK_W*(N_TOK-1-k) +: TOK_W] = (k < 9) ? 5'b10000 : 5'b00001;
    applyStimulus(e_dir, 1'b0);

    // Infix 1 + 2 * 3 - 4 / 5 ...
    for (int k = 0; k < N_TOK; k++)
      e_dir[TOK_W*(N_TOK-1-k) +: TOK_W] = (k % 2 == 0) ? 5'(k / 2 + 1) : {3'b100, 2'((k / 2) % 4)};
    applyStimulus(e_dir, 1'b1);

    // Operand first: the expression is complete after token 0.
    for (int k = 0; k < N_TOK; k++)
      e_dir[TOK_W*(N_TOK-1-k) +: TOK_W] = (k == 0) ? 5'b00011 : (k < 10) ? 5'b10000 : 5'b00001;
    applyStimulus(e_dir, 1'b0);

    // Illegal operator code at token 5 of an otherwise valid prefix.
    for (int k = 0; k < N_TOK; k++)
      e_dir[TOK_W*(N_TOK-1-k) +: TOK_W] = (k < 9) ? 5'b10000 : 5'b00001;
    e_dir[TOK_W*(N_TOK-1-5) +: TOK_W] = 5'b10111;
    applyStimulus(e_dir, 1'b0);

    for (int i = 0; i < 4; i++) applyStimulus(genPrefix(), 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(genInfix(), 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(corrupt(genPrefix()), 1'($urandom_range(1, 0)));
    applyStimulus(genInfix(), 1'b0);
    applyStimulus(genPrefix(), 1'b1);

    // start held high for 50 cycles with a fixed valid expression.
    e_dir   = genPrefix();
    expr_in = e_dir;
    opt_in  = 1'b0;
    start   = 1'b1;
    for (int i = 0; i < 50; i++) stepCycle();
    start = 1'b0;
    for (int i = 0; i < 45; i++) stepCycle();

    // Reset asserted during the fifth valid token.
    e_dir   = genPrefix();
    expr_in = e_dir;
    start   = 1'b1;
    stepCycle();
    load_cyc = cyc;
    start = 1'b0;
    while (cyc < load_cyc + LAT + 5) stepCycle();
    checkOutput("pre_reset_valid", 32'(tx_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 checkZero("async_reset");
    for (int c = cyc + 1; c < MAXC; c++) begin
      exp_busy[c] = 1'b0; exp_valid[c] = 1'b0; exp_opt[c] = 1'b0;
      exp_done[c] = 1'b0; exp_err[c] = 1'b0; exp_data[c] = '0;
    end
    next_free = 0;
    for (int i = 0; i < 3; i++) stepCycle();
    rst_n = 1'b1;
    applyStimulus(genPrefix(), 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
